// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package mem_arb_pkg;

    // Arbiter FSM states; the encoding is exported on the debug state port.
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_DONE   = 2'd2
    } arb_state_t;

    // Which requester owns (or last owned) the memory port.
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } arb_owner_t;

    // Smallest memory latency the FSM can express (one ACCESS cycle).
    localparam int ARB_LAT_MIN = 1;

    // The requester that is not the given one.
    function automatic arb_owner_t other_owner(input arb_owner_t owner);
        return (owner == OWN_IF) ? OWN_DM : OWN_IF;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between instruction fetch and load/store.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int DM_PRIORITY = 1
) (
    input  logic       if_req_i,
    input  logic       dm_req_i,
    input  arb_owner_t last_owner_i,
    output arb_owner_t owner_o,
    output logic       valid_o
);

    // A lone requester always wins; ties go to DM or alternate against the last owner.
    always_comb begin
        valid_o = if_req_i | dm_req_i;
        owner_o = OWN_IF;
        if (dm_req_i && !if_req_i) begin
            owner_o = OWN_DM;
        end else if (dm_req_i && if_req_i) begin
            owner_o = (DM_PRIORITY != 0) ? OWN_DM : other_owner(last_owner_i);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between instruction fetch and load/store.
// Each transaction: IDLE (sample + latch) -> ACCESS for MEM_LAT cycles -> DONE pulse.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LAT     = 1,
    parameter int DM_PRIORITY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic              if_gnt_o,
    output logic              dm_gnt_o,
    output logic              if_done_o,
    output logic              dm_done_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_wr_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o,
    output logic [1:0]        arb_state_o
);

    localparam int              CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    generate
        if (MEM_LAT < ARB_LAT_MIN) begin : g_lat_check
            $error("mem_port_arbiter: MEM_LAT must be at least 1");
        end
    endgenerate

    arb_state_t        state_q;
    arb_owner_t        owner_q;
    arb_owner_t        last_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic [DATA_W-1:0] rdata_q;
    logic              if_gnt_q;
    logic              dm_gnt_q;
    logic              if_done_q;
    logic              dm_done_q;
    logic              mem_wr_q;

    arb_owner_t        pick_owner;
    logic              pick_valid;

    mem_arb_pick #(
        .DM_PRIORITY (DM_PRIORITY)
    ) u_pick (
        .if_req_i     (if_req_i),
        .dm_req_i     (dm_req_i),
        .last_owner_i (last_q),
        .owner_o      (pick_owner),
        .valid_o      (pick_valid)
    );

    // Arbiter FSM with registered grant, done and write-strobe outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARB_IDLE;
            owner_q   <= OWN_IF;
            last_q    <= OWN_IF;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            rdata_q   <= '0;
            if_gnt_q  <= 1'b0;
            dm_gnt_q  <= 1'b0;
            if_done_q <= 1'b0;
            dm_done_q <= 1'b0;
            mem_wr_q  <= 1'b0;
        end else begin
            // Pulses default low; they are raised only on the cycle that needs them.
            mem_wr_q  <= 1'b0;
            if_done_q <= 1'b0;
            dm_done_q <= 1'b0;
            case (state_q)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        state_q <= ARB_ACCESS;
                        owner_q <= pick_owner;
                        cnt_q   <= CNT_LOAD;
                        if (pick_owner == OWN_DM) begin
                            addr_q   <= dm_addr_i;
                            wdata_q  <= dm_wdata_i;
                            we_q     <= dm_we_i;
                            mem_wr_q <= dm_we_i;
                            dm_gnt_q <= 1'b1;
                        end else begin
                            // Fetches never write; write data only tracks the DM side.
                            addr_q   <= if_addr_i;
                            we_q     <= 1'b0;
                            if_gnt_q <= 1'b1;
                        end
                    end
                end
                ARB_ACCESS: begin
                    if (cnt_q == '0) begin
                        if (!we_q) begin
                            rdata_q <= mem_rdata_i;
                        end
                        state_q   <= ARB_DONE;
                        if_done_q <= (owner_q == OWN_IF);
                        dm_done_q <= (owner_q == OWN_DM);
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ARB_DONE: begin
                    last_q   <= owner_q;
                    state_q  <= ARB_IDLE;
                    if_gnt_q <= 1'b0;
                    dm_gnt_q <= 1'b0;
                end
                default: begin
                    // Corrupted encoding: fall back to a quiet IDLE.
                    state_q  <= ARB_IDLE;
                    if_gnt_q <= 1'b0;
                    dm_gnt_q <= 1'b0;
                end
            endcase
        end
    end

    assign if_gnt_o    = if_gnt_q;
    assign dm_gnt_o    = dm_gnt_q;
    assign if_done_o   = if_done_q;
    assign dm_done_o   = dm_done_q;
    assign rdata_o     = rdata_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_wr_o    = mem_wr_q;
    assign busy_o      = (state_q != ARB_IDLE);
    assign arb_state_o = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT=1/DM priority, MEM_LAT=3/round-robin),
// directed scenarios plus a randomized run against a transaction-level model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  if_req, dm_req, dm_we;
    logic [1:0]  if_gnt, dm_gnt, if_done, dm_done, mem_wr, busy;
    logic [31:0] if_addr [2];
    logic [31:0] dm_addr [2];
    logic [31:0] dm_wdata [2];
    logic [31:0] mem_rdata [2];
    logic [31:0] rdata [2];
    logic [31:0] mem_addr [2];
    logic [31:0] mem_wdata [2];
    logic [1:0]  arb_state [2];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        mem_port_arbiter #(
            .ADDR_W      (32),
            .DATA_W      (32),
            .MEM_LAT     ((gi == 0) ? 1 : 3),
            .DM_PRIORITY ((gi == 0) ? 1 : 0)
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .if_req_i    (if_req[gi]),
            .if_addr_i   (if_addr[gi]),
            .dm_req_i    (dm_req[gi]),
            .dm_we_i     (dm_we[gi]),
            .dm_addr_i   (dm_addr[gi]),
            .dm_wdata_i  (dm_wdata[gi]),
            .if_gnt_o    (if_gnt[gi]),
            .dm_gnt_o    (dm_gnt[gi]),
            .if_done_o   (if_done[gi]),
            .dm_done_o   (dm_done[gi]),
            .rdata_o     (rdata[gi]),
            .mem_addr_o  (mem_addr[gi]),
            .mem_wdata_o (mem_wdata[gi]),
            .mem_wr_o    (mem_wr[gi]),
            .mem_rdata_i (mem_rdata[gi]),
            .busy_o      (busy[gi]),
            .arb_state_o (arb_state[gi])
        );
    end

    // ---------------- transaction-level reference model ----------------
    // A transaction sampled in cycle s completes (DONE) in cycle s+1+LAT; the
    // port is free to sample again in the cycle after DONE.
    bit          m_txn [2];
    int          m_s [2];
    int          m_d [2];
    bit          m_own [2];     // 1 = DM, 0 = IF
    bit          m_we [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_wdata [2];
    logic [31:0] m_rdata [2];
    bit          m_last [2];
    int          cyc;

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_txn[d] = 0; m_own[d] = 0; m_we[d] = 0; m_last[d] = 0;
            m_addr[d] = '0; m_wdata[d] = '0; m_rdata[d] = '0;
            m_s[d] = 0; m_d[d] = 0;
        end
        cyc = 0;
    endtask

    // Advance the model across the coming clock edge using the current inputs.
    task automatic model_tick();
        for (int d = 0; d < 2; d++) begin
            bit dm_wins;
            if (m_txn[d]) begin
                if (cyc == m_d[d] - 1 && !m_we[d]) m_rdata[d] = mem_rdata[d];
                if (cyc == m_d[d]) begin
                    m_last[d] = m_own[d];
                    m_txn[d] = 0;
                end
            end else if (if_req[d] || dm_req[d]) begin
                if (if_req[d] && dm_req[d]) dm_wins = (d == 0) ? 1'b1 : !m_last[d];
                else                        dm_wins = dm_req[d];
                m_txn[d] = 1; m_s[d] = cyc; m_d[d] = cyc + 1 + lat_of(d); m_own[d] = dm_wins;
                if (dm_wins) begin
                    m_we[d] = dm_we[d]; m_addr[d] = dm_addr[d]; m_wdata[d] = dm_wdata[d];
                end else begin
                    m_we[d] = 0; m_addr[d] = if_addr[d];
                end
            end
        end
        cyc++;
    endtask

    task automatic advance();
        model_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        for (int d = 0; d < 2; d++) begin
            if_req[d] = 0; dm_req[d] = 0; dm_we[d] = 0;
            if_addr[d] = '0; dm_addr[d] = '0; dm_wdata[d] = '0; mem_rdata[d] = '0;
        end
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        clear_inputs();
        @(posedge clk); #2;
        rst_n = 0;
        #1;
        for (int d = 0; d < 2; d++) begin
            total++;
            if ({if_gnt[d], dm_gnt[d], if_done[d], dm_done[d], mem_wr[d], busy[d], arb_state[d]} !== 8'b0) begin
                bad++; $display("FAIL reset_ctrl dut%0d: got %b want 00000000", d,
                                {if_gnt[d], dm_gnt[d], if_done[d], dm_done[d], mem_wr[d], busy[d], arb_state[d]});
            end
            total++;
            if ({rdata[d], mem_addr[d], mem_wdata[d]} !== 96'b0) begin
                bad++; $display("FAIL reset_data dut%0d: got rdata=%h addr=%h wdata=%h want 0", d, rdata[d], mem_addr[d], mem_wdata[d]);
            end
        end
        @(negedge clk);
        rst_n = 1;
        model_reset();
        @(posedge clk); #1;
    endtask

    task automatic test_fetch();
        if_req[0] = 1; if_addr[0] = 32'h10; mem_rdata[0] = 32'h0050_0093;
        @(negedge clk);
        total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL fetch_c0_busy: got %b want 0", busy[0]); end
        advance();
        if_addr[0] = 32'h99;   // must be ignored once the fetch is latched
        @(negedge clk);
        total++; if (mem_addr[0] !== 32'h10) begin bad++; $display("FAIL fetch_c1_addr: got %h want 00000010", mem_addr[0]); end
        total++;
        if ({if_gnt[0], dm_gnt[0], mem_wr[0], if_done[0], arb_state[0]} !== 6'b100001) begin
            bad++; $display("FAIL fetch_c1_ctrl: got %b want 100001", {if_gnt[0], dm_gnt[0], mem_wr[0], if_done[0], arb_state[0]});
        end
        advance();
        @(negedge clk);
        total++; if (if_done[0] !== 1'b1 || if_gnt[0] !== 1'b1 || mem_wr[0] !== 1'b0) begin
            bad++; $display("FAIL fetch_c2_done: got done=%b gnt=%b wr=%b want 1 1 0", if_done[0], if_gnt[0], mem_wr[0]);
        end
        total++; if (rdata[0] !== 32'h0050_0093) begin bad++; $display("FAIL fetch_c2_rdata: got %h want 00500093", rdata[0]); end
        advance();
        if_req[0] = 0;
        for (int k = 3; k < 5; k++) begin
            @(negedge clk);
            total++; if (busy[0] !== 1'b0 || if_done[0] !== 1'b0) begin
                bad++; $display("FAIL fetch_c%0d_idle: got busy=%b done=%b want 0 0", k, busy[0], if_done[0]);
            end
            advance();
        end
    endtask

    task automatic test_store();
        logic [31:0] rd_before;
        rd_before = m_rdata[1];
        dm_req[1] = 1; dm_we[1] = 1; dm_addr[1] = 32'h40; dm_wdata[1] = 32'hDEAD_BEEF; mem_rdata[1] = $urandom;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            total++; if (mem_wr[1] !== (k == 1)) begin bad++; $display("FAIL store_wr c%0d: got %b want %b", k, mem_wr[1], k == 1); end
            total++; if (dm_done[1] !== (k == 4)) begin bad++; $display("FAIL store_done c%0d: got %b want %b", k, dm_done[1], k == 4); end
            if (k >= 1 && k <= 4) begin
                total++;
                if ({dm_gnt[1], mem_addr[1], mem_wdata[1]} !== {1'b1, 32'h40, 32'hDEAD_BEEF}) begin
                    bad++; $display("FAIL store_bus c%0d: got gnt=%b addr=%h wdata=%h want 1 00000040 deadbeef", k, dm_gnt[1], mem_addr[1], mem_wdata[1]);
                end
            end
            total++; if (rdata[1] !== rd_before) begin bad++; $display("FAIL store_rdata c%0d: got %h want %h", k, rdata[1], rd_before); end
            advance();
            mem_rdata[1] = $urandom;
            if (k < 3) begin dm_addr[1] = $urandom; dm_wdata[1] = $urandom; end
            if (k == 4) begin dm_req[1] = 0; dm_we[1] = 0; end
        end
    endtask

    task automatic test_tie_prio();
        logic [31:0] rd_hist [8];
        if_req[0] = 1; if_addr[0] = 32'h20; dm_req[0] = 1; dm_we[0] = 0; dm_addr[0] = 32'h80;
        mem_rdata[0] = $urandom; rd_hist[0] = mem_rdata[0];
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            total++;
            if ({dm_gnt[0], dm_done[0], if_gnt[0], if_done[0]} !== {(k == 1 || k == 2), (k == 2), (k == 4 || k == 5), (k == 5)}) begin
                bad++; $display("FAIL tie_prio c%0d: got dgnt/ddone/ignt/idone=%b want %b", k,
                                {dm_gnt[0], dm_done[0], if_gnt[0], if_done[0]}, {(k == 1 || k == 2), (k == 2), (k == 4 || k == 5), (k == 5)});
            end
            if (k == 1 || k == 4) begin
                total++; if (mem_addr[0] !== ((k == 1) ? 32'h80 : 32'h20)) begin
                    bad++; $display("FAIL tie_prio_addr c%0d: got %h want %h", k, mem_addr[0], (k == 1) ? 32'h80 : 32'h20);
                end
            end
            if (k == 2 || k == 5) begin
                total++; if (rdata[0] !== rd_hist[k-1]) begin bad++; $display("FAIL tie_prio_rdata c%0d: got %h want %h", k, rdata[0], rd_hist[k-1]); end
            end
            advance();
            if (k < 7) begin mem_rdata[0] = $urandom; rd_hist[k+1] = mem_rdata[0]; end
            if (k == 2) dm_req[0] = 0;
            if (k == 5) if_req[0] = 0;
        end
    endtask

    // dut1 last served DM (the store), so a held tie alternates starting with IF.
    task automatic test_round_robin();
        int n;
        bit got_dm;
        logic [31:0] rd_prev;
        n = 0; rd_prev = '0;
        if_req[1] = 1; if_addr[1] = 32'h100; dm_req[1] = 1; dm_we[1] = 0; dm_addr[1] = 32'h200; mem_rdata[1] = $urandom;
        for (int k = 0; k < 40 && n < 4; k++) begin
            @(negedge clk);
            if (if_done[1] || dm_done[1]) begin
                got_dm = dm_done[1];
                total++; if (got_dm !== (n % 2 == 1)) begin bad++; $display("FAIL rr_order #%0d: got dm=%b want dm=%b", n, got_dm, n % 2 == 1); end
                total++; if (k !== 4 + 5 * n) begin bad++; $display("FAIL rr_timing #%0d: got cycle %0d want %0d", n, k, 4 + 5 * n); end
                total++; if (rdata[1] !== rd_prev || mem_addr[1] !== (got_dm ? 32'h200 : 32'h100)) begin
                    bad++; $display("FAIL rr_data #%0d: got rdata=%h addr=%h want %h %h", n, rdata[1], mem_addr[1], rd_prev, got_dm ? 32'h200 : 32'h100);
                end
                n++;
            end
            rd_prev = mem_rdata[1];
            advance();
            mem_rdata[1] = $urandom;
            if (n == 4) begin if_req[1] = 0; dm_req[1] = 0; end
        end
        total++; if (n !== 4) begin bad++; $display("FAIL rr_timeout: got %0d completions want 4", n); if_req[1] = 0; dm_req[1] = 0; end
    endtask

    task automatic test_mid_reset();
        dm_req[1] = 1; dm_we[1] = 1; dm_addr[1] = 32'h44; dm_wdata[1] = 32'h1234_5678;
        @(negedge clk);
        advance();
        #1;
        total++; if (mem_wr[1] !== 1'b1) begin bad++; $display("FAIL mrst_pre_wr: got %b want 1", mem_wr[1]); end
        rst_n = 0;
        #1;
        total++;
        if ({mem_wr[1], dm_gnt[1], busy[1], arb_state[1], rdata[1]} !== 37'b0) begin
            bad++; $display("FAIL mrst_drop: got wr=%b gnt=%b busy=%b st=%0d rdata=%h want all 0", mem_wr[1], dm_gnt[1], busy[1], arb_state[1], rdata[1]);
        end
        dm_req[1] = 0; dm_we[1] = 0;
        @(negedge clk);
        rst_n = 1;
        model_reset();
        for (int k = 0; k < 6; k++) begin
            advance();
            @(negedge clk);
            total++; if (dm_done[1] !== 1'b0 || busy[1] !== 1'b0) begin
                bad++; $display("FAIL mrst_quiet c%0d: got done=%b busy=%b want 0 0", k, dm_done[1], busy[1]);
            end
        end
        // From cold reset the last owner is IF, so a tie goes to DM first.
        advance();
        if_req[1] = 1; if_addr[1] = 32'h300; dm_req[1] = 1; dm_we[1] = 0; dm_addr[1] = 32'h304;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            total++;
            if ({dm_gnt[1], dm_done[1], if_gnt[1], if_done[1]} !== {(k >= 1 && k <= 4), (k == 4), (k >= 6), (k == 9)}) begin
                bad++; $display("FAIL mrst_cold c%0d: got dgnt/ddone/ignt/idone=%b want %b", k,
                                {dm_gnt[1], dm_done[1], if_gnt[1], if_done[1]}, {(k >= 1 && k <= 4), (k == 4), (k >= 6), (k == 9)});
            end
            advance();
            if (k == 4) dm_req[1] = 0;
            if (k == 9) if_req[1] = 0;
        end
    endtask

    task automatic test_req_drop();
        int pulses;
        pulses = 0;
        dm_req[1] = 1; dm_we[1] = 0; dm_addr[1] = 32'h50;
        @(negedge clk);
        advance();
        dm_req[1] = 0;
        for (int k = 1; k < 10; k++) begin
            @(negedge clk);
            if (dm_done[1] === 1'b1) pulses++;
            total++; if (dm_done[1] !== (k == 4) || busy[1] !== (k <= 4)) begin
                bad++; $display("FAIL drop c%0d: got done=%b busy=%b want %b %b", k, dm_done[1], busy[1], k == 4, k <= 4);
            end
            advance();
        end
        total++; if (pulses !== 1) begin bad++; $display("FAIL drop_pulses: got %0d want 1", pulses); end
    endtask

    task automatic test_random();
        bit drop_if [2];
        bit drop_dm [2];
        do_reset();
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                bit act, at_done;
                logic [7:0] ectrl;
                act = m_txn[d];
                at_done = act && (cyc == m_d[d]);
                ectrl = {act, act && !m_own[d], act && m_own[d], at_done && !m_own[d], at_done && m_own[d],
                         act && (cyc == m_s[d] + 1) && m_we[d], act ? (at_done ? 2'd2 : 2'd1) : 2'd0};
                total++;
                if ({busy[d], if_gnt[d], dm_gnt[d], if_done[d], dm_done[d], mem_wr[d], arb_state[d]} !== ectrl) begin
                    bad++; $display("FAIL rand_ctrl dut%0d t%0d: got %b want %b", d, t,
                                    {busy[d], if_gnt[d], dm_gnt[d], if_done[d], dm_done[d], mem_wr[d], arb_state[d]}, ectrl);
                end
                total++;
                if ({rdata[d], mem_addr[d], mem_wdata[d]} !== {m_rdata[d], m_addr[d], m_wdata[d]}) begin
                    bad++; $display("FAIL rand_data dut%0d t%0d: got %h %h %h want %h %h %h", d, t,
                                    rdata[d], mem_addr[d], mem_wdata[d], m_rdata[d], m_addr[d], m_wdata[d]);
                end
                drop_if[d] = at_done && !m_own[d];
                drop_dm[d] = at_done && m_own[d];
            end
            advance();
            for (int d = 0; d < 2; d++) begin
                mem_rdata[d] = $urandom;
                if (drop_if[d]) if_req[d] = 0;
                else if (!if_req[d]) begin
                    if ($urandom_range(9) < 4) begin if_req[d] = 1; if_addr[d] = $urandom; end
                end else if ($urandom_range(9) < 3) if_addr[d] = $urandom;
                if (drop_dm[d]) dm_req[d] = 0;
                else if (!dm_req[d]) begin
                    if ($urandom_range(9) < 4) begin
                        dm_req[d] = 1; dm_addr[d] = $urandom; dm_wdata[d] = $urandom; dm_we[d] = $urandom_range(1);
                    end
                end else if ($urandom_range(9) < 3) begin
                    dm_addr[d] = $urandom; dm_wdata[d] = $urandom; dm_we[d] = $urandom_range(1);
                end
            end
        end
    endtask

    initial begin
        clear_inputs();
        model_reset();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_fetch();
        test_store();
        test_tie_prio();
        test_round_robin();
        test_mid_reset();
        test_req_drop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data memory port between two requesters of the multicycle core: instruction fetch (IF) and load/store (DM).
- Accepts one request per transaction, drives the memory address, write data and write strobe, and waits a fixed MEM_LAT cycles.
- Returns read data with a one-cycle DONE pulse to the winning requester.
- Sits between the control unit's fetch/ld/sd states and the memory. The control unit holds its state until DONE.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, memory data width.
- MEM_LAT, 1, memory read/write latency in cycles. Must be >= 1; elaboration-time assertion.
- DM_PRIORITY, 1, tie-break mode. 1 = DM always wins ties; 0 = round-robin against the last owner.

Ports:
- CLK  in  1  clock, rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- IF_REQ  in  1  fetch request; held high until IF_DONE.
- IF_ADDR  in  ADDR_W  fetch address.
- DM_REQ  in  1  load/store request; held high until DM_DONE.
- DM_WE  in  1  1 = store, 0 = load.
- DM_ADDR  in  ADDR_W  load/store address.
- DM_WDATA  in  DATA_W  store data.
- IF_GNT  out  1  IF owns the port (ACCESS and DONE states).
- DM_GNT  out  1  DM owns the port (ACCESS and DONE states).
- IF_DONE  out  1  one-cycle completion pulse to IF.
- DM_DONE  out  1  one-cycle completion pulse to DM.
- RDATA  out  DATA_W  read data; valid in the DONE cycle and held until the next capture.
- MEM_ADDR  out  ADDR_W  memory address.
- MEM_WDATA  out  DATA_W  memory write data.
- MEM_WR  out  1  memory write strobe.
- MEM_RDATA  in  DATA_W  memory read data.
- BUSY  out  1  state != IDLE.
- ARB_STATE  out  2  current state, for debug/waveform display.

Behaviour:
- Reset (RESET_N low, asynchronous):
  - State goes to IDLE.
  - All outputs are 0: GNTs, DONEs, MEM_WR, BUSY, RDATA, MEM_ADDR, MEM_WDATA.
  - Last-owner register = IF.
  - Counter = 0.
- Reset mid-transaction aborts it immediately. MEM_WR falls in the same cycle reset asserts. No DONE is issued after release.
- States: IDLE(0), ACCESS(1), DONE(2).
- IDLE:
  - If any REQ is high, pick the owner.
  - Register owner, address, WE and WDATA. IF transactions always have WE = 0.
  - Load counter = MEM_LAT-1 and move to ACCESS.
  - With no request, stay in IDLE.
- Arbitration:
  - Only one REQ high: that requester wins.
  - Both high, DM_PRIORITY=1: DM wins.
  - Both high, DM_PRIORITY=0: the requester that is not the last owner wins.
- ACCESS:
  - MEM_ADDR and MEM_WDATA are driven from the latched values for the whole state.
  - MEM_WR = latched WE, only in the first ACCESS cycle.
  - GNT of the owner is high.
  - Counter decrements each cycle.
  - When counter = 0: capture MEM_RDATA into RDATA (loads only; a store leaves RDATA unchanged) and go to DONE.
- DONE:
  - Owner's DONE = 1 for exactly one cycle; its GNT stays high.
  - Update last owner. Go to IDLE unconditionally.
- Latency: request sampled in cycle N means DONE in cycle N+1+MEM_LAT. Minimum gap between back-to-back transactions is one IDLE cycle.
- Request inputs are sampled only in IDLE:
  - A REQ dropped during ACCESS still completes and still pulses DONE.
  - Address/data changes during ACCESS are ignored.
- The losing requester keeps REQ high and is served in the next IDLE. There is no queue deeper than one pending per requester.
- MEM_ADDR and MEM_WDATA keep their last latched values while in IDLE and DONE. MEM_WR is 0 outside the first ACCESS cycle.
- Unknown ARB_STATE encoding (3) recovers to IDLE on the next clock.

Decomposition:
- Package mem_arb_pkg:
  - arb_state_t enum {ARB_IDLE, ARB_ACCESS, ARB_DONE}, 2-bit.
  - arb_owner_t enum {OWN_IF, OWN_DM}.
  - Constant ARB_LAT_MIN = 1.
- Sub-module mem_arb_pick: combinational winner select from IF_REQ, DM_REQ, last owner and DM_PRIORITY; outputs arb_owner_t and a valid flag.
- The FSM, counter and latches live in mem_port_arbiter.

Test Plan:
- Fetch only, MEM_LAT=1: IF_REQ=1, IF_ADDR=0x10 at cycle 0, MEM_RDATA=0x00500093 → MEM_ADDR=0x10 at cycle 1, IF_DONE=1 and RDATA=0x00500093 at cycle 2, MEM_WR=0 throughout.
- Store, MEM_LAT=3: DM_REQ=1, DM_WE=1, DM_ADDR=0x40, DM_WDATA=0xDEADBEEF → MEM_WR=1 only in cycle 1, DM_DONE at cycle 4, RDATA unchanged.
- Tie, DM_PRIORITY=1: IF_REQ and DM_REQ both held high → DM served first (DM_DONE cycle 2), IF served next (IF_GNT cycle 4, IF_DONE cycle 5).
- Tie, DM_PRIORITY=0, both held high for 4 transactions → grant order IF, DM, IF, DM.
- Mid-transaction reset: RESET_N low during ACCESS with MEM_LAT=3 and a store → MEM_WR, GNT and BUSY drop in the same cycle; no DONE after release; next request behaves as from cold reset.
- REQ dropped during ACCESS → DONE still pulses once; no second transaction starts.
